l1_cache_ctrl: RTL

L1_CACHE_CTRL -- requirements
Module: l1_cache_ctrl

---
 rtl/l1_cache_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/l1_cache_ctrl.sv
// rtl/l1_cache_ctrl.sv - direct-mapped write-back L1 cache controller
// Tag/valid/dirty live here; line data sits in an external array read combinationally.
module l1_cache_ctrl #(
  parameter int INDEX_BITS  = 6,
  parameter int OFFSET_BITS = 4,
  parameter int TAG_BITS    = 32 - INDEX_BITS - OFFSET_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  int_req_valid,
  input  logic                  int_req_we,
  input  logic [31:0]           int_req_addr,
  input  logic [31:0]           int_req_wdata,
  input  logic [3:0]            int_req_wstrb,
  output logic                  int_resp_valid,
  output logic [31:0]           int_resp_rdata,
  output logic                  int_stall,
  output logic [INDEX_BITS-1:0] da_index,
  input  logic [127:0]          da_rdata,
  output logic                  da_we,
  output logic [15:0]           da_wstrb,
  output logic [127:0]          da_wdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [31:0]           mem_addr,
  output logic [127:0]          mem_wdata,
  input  logic                  mem_ack,
  input  logic [127:0]          mem_rdata
);
  localparam int LINES = 1 << INDEX_BITS;

  typedef enum logic [1:0] {IDLE, LOOKUP, WRITEBACK, REFILL} state_t;

  state_t                state, state_next;
  logic [LINES-1:0]      valid, dirty;
  logic [TAG_BITS-1:0]   tag_mem [LINES];
  logic                  req_we;
  logic [31:2]           req_addr;
  logic [31:0]           req_wdata;
  logic [3:0]            req_wstrb;
  logic [INDEX_BITS-1:0] idx;
  logic [TAG_BITS-1:0]   req_tag;
  logic [1:0]            word;
  logic                  hit, set_dirty, refill_done;
  logic                  unused_addr_bits;

  // Byte offset within a word never reaches the data path.
  assign unused_addr_bits = ^int_req_addr[1:0];

  assign idx     = req_addr[OFFSET_BITS +: INDEX_BITS];
  assign req_tag = req_addr[31 -: TAG_BITS];
  assign word    = req_addr[3:2];
  assign hit     = valid[idx] && (tag_mem[idx] == req_tag);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      valid     <= '0;
      dirty     <= '0;
      req_we    <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      req_wstrb <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && int_req_valid) begin
        req_we    <= int_req_we;
        req_addr  <= int_req_addr[31:2];
        req_wdata <= int_req_wdata;
        req_wstrb <= int_req_wstrb;
      end
      if (refill_done) begin
        valid[idx] <= 1'b1;
        dirty[idx] <= 1'b0;
      end else if (set_dirty) begin
        dirty[idx] <= 1'b1;
      end
    end
  end

  // Tags need no reset: valid[] gates every comparison.
  always_ff @(posedge clk) begin
    if (refill_done) tag_mem[idx] <= req_tag;
  end

  always_comb begin
    state_next     = state;
    int_stall      = 1'b0;
    int_resp_valid = 1'b0;
    int_resp_rdata = '0;
    da_index       = '0;
    da_we          = 1'b0;
    da_wstrb       = '0;
    da_wdata       = '0;
    mem_req        = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    set_dirty      = 1'b0;
    refill_done    = 1'b0;
    case (state)
      IDLE: begin
        if (int_req_valid) state_next = LOOKUP;
      end
      LOOKUP: begin
        int_stall = 1'b1;
        da_index  = idx;
        if (hit) begin
          int_resp_valid = 1'b1;
          state_next     = IDLE;
          if (req_we) begin
            da_we     = 1'b1;
            da_wdata  = {4{req_wdata}};
            da_wstrb  = 16'(req_wstrb) << {word, 2'b00};
            set_dirty = |req_wstrb;
          end else begin
            int_resp_rdata = da_rdata[{word, 5'b00000} +: 32];
          end
        end else if (valid[idx] && dirty[idx]) begin
          state_next = WRITEBACK;
        end else begin
          state_next = REFILL;
        end
      end
      WRITEBACK: begin
        int_stall = 1'b1;
        da_index  = idx;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {tag_mem[idx], idx, {OFFSET_BITS{1'b0}}};
        mem_wdata = da_rdata;
        if (mem_ack) state_next = REFILL;
      end
      REFILL: begin
        int_stall = 1'b1;
        da_index  = idx;
        mem_req   = 1'b1;
        mem_addr  = {req_addr[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
        // Refill returns to LOOKUP so the original request completes as a hit.
        if (mem_ack) begin
          da_we       = 1'b1;
          da_wstrb    = 16'hFFFF;
          da_wdata    = mem_rdata;
          refill_done = 1'b1;
          state_next  = LOOKUP;
        end
      end
      default: state_next = IDLE;
    endcase
  end
endmodule
